// File: rtl/pps_phase_mon_if.sv
// Record stream from the PPS phase monitor to the answer path: one signed phase record
// per channel per epoch, closed by a record flagged last.
interface pps_phase_mon_if #(
   parameter int N_CH  = 4,
   parameter int CNT_W = 30
);
   localparam int CH_W = $clog2(N_CH);

   // valid/ready: a record transfers on every rising clock edge where valid and ready are
   // both high; while valid is high and ready low, ch/phase/miss/last hold their values,
   // and valid only drops after the record has transferred.
   logic             valid;
   logic             ready;
   logic [CH_W-1:0]  ch;
   logic [CNT_W-1:0] phase;
   logic             miss;
   logic             last;

   modport master (output valid, ch, phase, miss, last, input ready);
   modport slave  (input valid, ch, phase, miss, last, output ready);
endinterface

// File: rtl/pps_phase_mon.sv
// N-channel PPS phase monitor: channel 0 opens a +/-WIN capture window, then every channel's
// timestamp offset against the reference is streamed out, with miss, overrun and ref-loss status.
module pps_phase_mon #(
   parameter int N_CH    = 4,
   parameter int CNT_W   = 30,
   parameter int SYNC_ST = 2,
   parameter int WIN     = 50_000_000,
   parameter int REF_TO  = 110_000_000
) (
   input  logic            i_clk,
   input  logic            i_res,
   input  logic [N_CH-1:0] i_pps,
   pps_phase_mon_if.master rec,
   output logic            o_ref_lost,
   output logic [7:0]      o_ovr_cnt,
   output logic [1:0]      o_dbg_state
);
   localparam int CH_W = $clog2(N_CH);
   localparam int WD_W = $clog2(REF_TO + 2);
   localparam logic [CH_W-1:0]         LAST_CH = CH_W'(N_CH - 1);
   localparam logic signed [CNT_W-1:0] WIN_P   = CNT_W'(WIN);
   localparam logic signed [CNT_W-1:0] WIN_N   = -WIN_P;
   localparam logic [WD_W-1:0]         WD_LIM  = WD_W'(REF_TO);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_COLLECT = 2'd1,
      S_REPORT  = 2'd2
   } state_t;

   state_t state, state_nx;

   logic [N_CH-1:0]  sync_q [SYNC_ST];
   logic [N_CH-1:0]  pps_prev;
   logic [N_CH-1:0]  pps_edge;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] ts [N_CH];
   logic [CNT_W-1:0] ts_ref;
   logic [N_CH-1:0]  fresh;
   logic [CNT_W-1:0] win_cnt;
   logic [WD_W-1:0]  wd;
   logic [CH_W-1:0]  rec_k;

   logic                    ref_edge;
   logic                    hs;
   logic                    last_hs;
   logic [CH_W-1:0]         sel_k;
   logic signed [CNT_W-1:0] sel_d;
   logic                    sel_miss;
   logic [CNT_W-1:0]        sel_phase;

   assign ref_edge    = pps_edge[0];
   assign hs          = rec.valid & rec.ready;
   assign last_hs     = hs & (rec_k == LAST_CH);
   assign o_ref_lost  = (wd > WD_LIM);
   assign o_dbg_state = state;

   // Identical latency on every channel, so it cancels out of the phase difference.
   always_ff @(posedge i_clk or posedge i_res) begin
      if (i_res) begin
         for (int i = 0; i < SYNC_ST; i++) sync_q[i] <= '0;
         pps_prev <= '0;
         pps_edge <= '0;
      end else begin
         sync_q[0] <= i_pps;
         for (int i = 1; i < SYNC_ST; i++) sync_q[i] <= sync_q[i-1];
         pps_prev <= sync_q[SYNC_ST-1];
         pps_edge <= sync_q[SYNC_ST-1] & ~pps_prev;
      end
   end

   always_ff @(posedge i_clk or posedge i_res) begin
      if (i_res) state <= S_IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:    if (ref_edge) state_nx = S_COLLECT;
         S_COLLECT: if (win_cnt == '0) state_nx = S_REPORT;
         S_REPORT:  if (last_hs) state_nx = S_IDLE;
         default:   state_nx = S_IDLE;
      endcase
   end

   // Record to load next: the current index when first presenting, the following one on a handshake.
   always_comb begin
      sel_k = rec_k;
      if (rec.valid && rec_k != LAST_CH) sel_k = rec_k + CH_W'(1);
      sel_d     = ts[sel_k] - ts_ref;
      sel_miss  = ~fresh[sel_k] | (sel_d > WIN_P) | (sel_d < WIN_N);
      sel_phase = sel_miss ? '0 : sel_d;
      if (sel_k == '0) begin
         sel_miss  = 1'b0;
         sel_phase = '0;
      end
   end

   always_ff @(posedge i_clk or posedge i_res) begin
      if (i_res) begin
         cnt       <= '0;
         for (int k = 0; k < N_CH; k++) ts[k] <= '0;
         ts_ref    <= '0;
         fresh     <= '0;
         win_cnt   <= '0;
         wd        <= '0;
         o_ovr_cnt <= '0;
         rec_k     <= '0;
         rec.valid <= 1'b0;
         rec.ch    <= '0;
         rec.phase <= '0;
         rec.miss  <= 1'b0;
         rec.last  <= 1'b0;
      end else begin
         cnt <= cnt + CNT_W'(1);

         // The end-of-epoch clear beats an edge landing in the same cycle.
         for (int k = 0; k < N_CH; k++) begin
            if (pps_edge[k]) ts[k] <= cnt;
            fresh[k] <= last_hs ? 1'b0 : (fresh[k] | pps_edge[k]);
         end

         if (state == S_IDLE && ref_edge) begin
            ts_ref  <= cnt;
            win_cnt <= CNT_W'(WIN);
            wd      <= '0;
         end else begin
            if (state == S_COLLECT && win_cnt != '0) win_cnt <= win_cnt - CNT_W'(1);
            if (wd <= WD_LIM) wd <= wd + WD_W'(1);
         end

         if (state != S_IDLE && ref_edge && o_ovr_cnt != 8'hFF) o_ovr_cnt <= o_ovr_cnt + 8'd1;

         if (state == S_REPORT) begin
            if (!rec.valid || (hs && rec_k != LAST_CH)) begin
               rec_k     <= sel_k;
               rec.valid <= 1'b1;
               rec.ch    <= sel_k;
               rec.phase <= sel_phase;
               rec.miss  <= sel_miss;
               rec.last  <= (sel_k == LAST_CH);
            end else if (hs) begin
               rec.valid <= 1'b0;
            end
         end else begin
            rec_k     <= '0;
            rec.valid <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_pps_phase_mon.sv
// Randomised bench for pps_phase_mon: drives PPS epochs with known edge offsets and checks the
// record stream, overrun counter and reference-loss flag against a per-epoch arithmetic model.
module tb_pps_phase_mon;
   localparam int N_CH    = 4;
   localparam int CNT_W   = 12;
   localparam int SYNC_ST = 2;
   localparam int WIN     = 1000;
   localparam int REF_TO  = 3000;
   localparam int CH_W    = $clog2(N_CH);
   localparam int RW      = CH_W + CNT_W + 2;
   localparam int NONE    = -100000;
   localparam int PW      = 3;
   localparam int LAT     = SYNC_ST + 2;

   logic            clk;
   logic            i_res;
   logic [N_CH-1:0] i_pps;
   logic            o_ref_lost;
   logic [7:0]      o_ovr_cnt;
   logic [1:0]      o_dbg_state;

   pps_phase_mon_if #(.N_CH(N_CH), .CNT_W(CNT_W)) rec_if ();

   pps_phase_mon #(
      .N_CH(N_CH), .CNT_W(CNT_W), .SYNC_ST(SYNC_ST), .WIN(WIN), .REF_TO(REF_TO)
   ) dut (
      .i_clk       (clk),
      .i_res       (i_res),
      .i_pps       (i_pps),
      .rec         (rec_if),
      .o_ref_lost  (o_ref_lost),
      .o_ovr_cnt   (o_ovr_cnt),
      .o_dbg_state (o_dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- scoreboard ----------------
   logic [RW-1:0] exp_q[$];
   int n_checks = 0;
   int n_errors = 0;
   int exp_ovr  = 0;
   int last_ref_c = 0;
   int rel_c = 0;
   bit hold_low = 1'b0;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [RW-1:0] model_rec(input int k, input int off);
      logic [CNT_W-1:0] ph;
      logic             m;
      logic [CH_W-1:0]  ch;
      ch = CH_W'(k);
      if (k == 0) begin
         ph = '0; m = 1'b0;
      end else if (off == NONE || off > WIN || off < -WIN) begin
         ph = '0; m = 1'b1;
      end else begin
         ph = CNT_W'(off); m = 1'b0;
      end
      return {ch, ph, m, (k == N_CH - 1)};
   endfunction

   // Monitor: idle cycles must show no record; otherwise the front record must be presented.
   always @(negedge clk) begin
      if (!i_res) begin
         if (exp_q.size() == 0) begin
            check_val("idle_valid", 64'(rec_if.valid), 64'd0);
         end else if (rec_if.valid) begin
            check_val("rec", 64'({rec_if.ch, rec_if.phase, rec_if.miss, rec_if.last}),
                      64'(exp_q[0]));
            if (rec_if.ready) void'(exp_q.pop_front());
         end
      end
   end

   // Downstream readiness: random unless a test forces a stall.
   initial begin
      rec_if.ready = 1'b0;
      forever begin
         @(posedge clk);
         #2 rec_if.ready = hold_low ? 1'b0 : ($urandom_range(0, 3) != 0);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic push_expected(input int offs[N_CH]);
      for (int k = 0; k < N_CH; k++) exp_q.push_back(model_rec(k, k == 0 ? 0 : offs[k]));
   endtask

   task automatic drive_pulses(input int offs[N_CH]);
      int lo;
      logic [N_CH-1:0] v;
      lo = 0;
      for (int k = 1; k < N_CH; k++) if (offs[k] != NONE && offs[k] < lo) lo = offs[k];
      for (int t = lo; t <= WIN + 2 + PW; t++) begin
         step();
         v = '0;
         v[0] = (t >= 0 && t < PW);
         for (int k = 1; k < N_CH; k++)
            v[k] = (offs[k] != NONE && t >= offs[k] && t < offs[k] + PW);
         i_pps = v;
         if (t == 0) last_ref_c = cyc;
      end
      step();
      i_pps = '0;
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 2000) begin
         step();
         n++;
      end
      if (exp_q.size() != 0) begin
         check_val("drain_timeout", 64'(exp_q.size()), 64'd0);
         exp_q.delete();
      end
   endtask

   task automatic wait_valid();
      int n;
      n = 0;
      while (!rec_if.valid && n < 200) begin
         step();
         n++;
      end
      check_val("valid_seen", 64'(rec_if.valid), 64'd1);
   endtask

   task automatic run_epoch(input int offs[N_CH], input bit do_stall);
      push_expected(offs);
      if (do_stall) hold_low = 1'b1;
      drive_pulses(offs);
      if (do_stall) begin
         wait_valid();
         repeat (5) step();
         i_pps[0] = 1'b1;
         repeat (PW) step();
         i_pps[0] = 1'b0;
         exp_ovr++;
         repeat (15) step();
         hold_low = 1'b0;
      end
      wait_drain();
      if (do_stall) repeat (WIN + 100) step();
      @(negedge clk);
      check_val("ovr_cnt", 64'(o_ovr_cnt), 64'(exp_ovr));
      check_val("ref_lost", 64'(o_ref_lost), 64'd0);
   endtask

   function automatic int rand_off();
      int r;
      int b;
      r = $urandom_range(0, 7);
      if (r < 2) return NONE;
      if (r < 4) begin
         b = $urandom_range(0, 4);
         case (b)
            0: return -WIN - 1;
            1: return -WIN;
            2: return 0;
            3: return WIN;
            default: return WIN + 1;
         endcase
      end
      return $urandom_range(0, 2100) - 1100;
   endfunction

   // ---------------- main sequence ----------------
   initial begin
      int offs[N_CH];
      i_res = 1'b1;
      i_pps = '0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      check_val("rst_valid", 64'(rec_if.valid), 64'd0);
      check_val("rst_ovr", 64'(o_ovr_cnt), 64'd0);
      check_val("rst_lost", 64'(o_ref_lost), 64'd0);
      check_val("rst_rec", 64'({rec_if.ch, rec_if.phase, rec_if.miss, rec_if.last}), 64'd0);
      step();
      i_res = 1'b0;
      rel_c = cyc;
      repeat (20) step();

      // Basic offsets, then window boundaries.
      offs = '{0, 37, -12, NONE};
      run_epoch(offs, 1'b0);
      offs = '{0, WIN, -WIN - 1, WIN + 1};
      run_epoch(offs, 1'b0);
      offs = '{0, -WIN, 0, NONE};
      run_epoch(offs, 1'b0);

      for (int e = 0; e < 6; e++) begin
         offs[0] = 0;
         for (int k = 1; k < N_CH; k++) offs[k] = rand_off();
         repeat ($urandom_range(0, 200)) step();
         run_epoch(offs, 1'b0);
      end

      // Reference lands just before the counter wraps; channel 1 follows after the wrap.
      while (((cyc - rel_c) % (1 << CNT_W)) != (1 << CNT_W) - 10) step();
      offs = '{0, 10, NONE, 0};
      run_epoch(offs, 1'b0);

      // Long stall during reporting with an extra reference edge.
      offs = '{0, 250, -300, 999};
      run_epoch(offs, 1'b1);

      // Reset while a record is waiting.
      offs = '{0, 5, NONE, NONE};
      hold_low = 1'b1;
      push_expected(offs);
      drive_pulses(offs);
      wait_valid();
      repeat (3) step();
      i_res = 1'b1;
      #1;
      check_val("rst_mid_valid", 64'(rec_if.valid), 64'd0);
      exp_q.delete();
      exp_ovr = 0;
      repeat (3) step();
      check_val("rst_mid_ovr", 64'(o_ovr_cnt), 64'd0);
      i_res = 1'b0;
      rel_c = cyc;
      hold_low = 1'b0;
      repeat (20) step();
      offs = '{0, NONE, NONE, NONE};
      run_epoch(offs, 1'b0);

      // Reference loss: stop pulses and check the exact rising cycle.
      while (cyc < last_ref_c + LAT + REF_TO) step();
      @(negedge clk);
      check_val("lost_early", 64'(o_ref_lost), 64'd0);
      @(posedge clk);
      @(negedge clk);
      check_val("lost_rise", 64'(o_ref_lost), 64'd1);
      repeat (50) step();
      check_val("lost_hold", 64'(o_ref_lost), 64'd1);
      offs = '{0, -40, NONE, 70};
      run_epoch(offs, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
